// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-in/serial-out stage with valid/ready load and gap-free word chaining
// Ports: clk; reset (sync, active-low); data[WIDTH-1:0], valid in; ready (combinational) out;
//        x (serial bit), busy (word in flight), last (bit 0 on x) registered out
module piso_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             x,
  output logic             busy,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  // a new word may load while idle or on the final bit of the current word, which gives gap-free chaining
  assign ready = reset && (state == IDLE || last);
  // the word's MSB goes straight to x at load, so sr[WIDTH-2] is always the next bit to emit;
  // the vacated low bit takes the old MSB, which is never emitted again
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      x     <= IDLE_BIT;
      busy  <= 1'b0;
      last  <= 1'b0;
    end else if (valid && ready) begin
      state <= SHIFT;
      sr    <= data;
      cnt   <= CW'(WIDTH - 1);
      x     <= data[WIDTH-1];
      busy  <= 1'b1;
      last  <= 1'b0;
    end else if (state == SHIFT && cnt != '0) begin
      sr    <= {sr[WIDTH-2:0], sr[WIDTH-1]};
      x     <= sr[WIDTH-2];
      cnt   <= cnt - 1'b1;
      last  <= (cnt == CW'(1));
    end else begin
      state <= IDLE;
      x     <= IDLE_BIT;
      busy  <= 1'b0;
      last  <= 1'b0;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer (8-bit idle-0 and 4-bit idle-1 instances)
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data8 = '0;
  logic       valid8 = 1'b0;
  logic [3:0] data4 = '0;
  logic       valid4 = 1'b0;
  logic       ready8, x8, busy8, last8;
  logic       ready4, x4, busy4, last4;
  logic [2:0] q8[$];
  logic [2:0] q4[$];
  logic [2:0] e8, e4;
  logic       mon = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .reset(reset), .data(data8), .valid(valid8),
    .ready(ready8), .x(x8), .busy(busy8), .last(last8)
  );

  piso_serializer #(.WIDTH(4), .IDLE_BIT(1'b1)) dut4 (
    .clk(clk), .reset(reset), .data(data4), .valid(valid4),
    .ready(ready4), .x(x4), .busy(busy4), .last(last4)
  );

  always @(negedge clk)
    if (mon) begin
      e8 = (q8.size() != 0) ? q8.pop_front() : 3'b000;
      e4 = (q4.size() != 0) ? q4.pop_front() : 3'b100;
      checks += 2;
      if ({x8, busy8, last8} !== e8) begin
        errors++;
        $display("FAIL stream8 t=%0t x/busy/last=%b required=%b", $time, {x8, busy8, last8}, e8);
      end
      if ({x4, busy4, last4} !== e4) begin
        errors++;
        $display("FAIL stream4 t=%0t x/busy/last=%b required=%b", $time, {x4, busy4, last4}, e4);
      end
    end

  task automatic push8(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) q8.push_back({d[7-i], 1'b1, i == 7});
  endtask

  task automatic push4(input logic [3:0] d);
    for (int i = 0; i < 4; i++) q4.push_back({d[3-i], 1'b1, i == 3});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (q8.size() != 0 || q4.size() != 0); i++) step();
    checks++;
    if (q8.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain pending8=%0d pending4=%0d required=0", q8.size(), q4.size());
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (ready8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready ready=%b required=0", ready8);
    end
    step();
    checks += 2;
    if ({x8, busy8, last8} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state8 x/busy/last=%b required=000", {x8, busy8, last8});
    end
    if ({x4, busy4, last4} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state4 x/busy/last=%b required=100", {x4, busy4, last4});
    end
    mon = 1'b1;
  endtask

  task automatic test_single();
    reset = 1'b1;
    valid8 = 1'b1;
    data8 = 8'hA5;
    #1;
    checks++;
    if (ready8 !== 1'b1) begin
      errors++;
      $display("FAIL single_ready ready=%b required=1", ready8);
    end
    step();
    push8(8'hA5, 8);
    valid8 = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    valid8 = 1'b1;
    data8 = 8'hAA;
    step();
    push8(8'hAA, 8);
    data8 = 8'h0F;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (ready8 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_low bit=%0d ready=%b required=0", i, ready8);
      end
      step();
    end
    checks++;
    if (ready8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_last ready=%b required=1", ready8);
    end
    step();
    push8(8'h0F, 8);
    valid8 = 1'b0;
    wait_drain();
  endtask

  task automatic test_backpressure();
    valid8 = 1'b1;
    data8 = 8'h3C;
    step();
    push8(8'h3C, 8);
    valid8 = 1'b0;
    repeat (2) step();
    valid8 = 1'b1;
    data8 = 8'hFF;
    for (int i = 3; i < 8; i++) begin
      #1;
      checks++;
      if (ready8 !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_low bit=%0d ready=%b required=0", i, ready8);
      end
      step();
    end
    checks++;
    if (ready8 !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_last ready=%b required=1", ready8);
    end
    step();
    push8(8'hFF, 8);
    valid8 = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_word();
    valid8 = 1'b1;
    data8 = 8'hC3;
    step();
    push8(8'hC3, 4);
    valid8 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    checks++;
    if (ready8 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready ready=%b required=0", ready8);
    end
    step();
    reset = 1'b1;
    checks++;
    if ({x8, busy8, last8} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_state x/busy/last=%b required=000", {x8, busy8, last8});
    end
    repeat (8) step();
    wait_drain();
  endtask

  task automatic test_reset_accept();
    reset = 1'b0;
    valid8 = 1'b1;
    data8 = 8'h5A;
    valid4 = 1'b1;
    data4 = 4'b1001;
    #1;
    checks++;
    if (ready8 !== 1'b0 || ready4 !== 1'b0) begin
      errors++;
      $display("FAIL rstacc_ready ready8=%b ready4=%b required=0", ready8, ready4);
    end
    step();
    reset = 1'b1;
    valid8 = 1'b0;
    valid4 = 1'b0;
    #1;
    checks++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL rstacc_idle ready=%b busy=%b required=1/0", ready8, busy8);
    end
    repeat (10) step();
  endtask

  task automatic test_idle_level();
    valid4 = 1'b1;
    data4 = 4'b0110;
    step();
    push4(4'b0110);
    valid4 = 1'b0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_reset_accept();
    test_idle_level();
    mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that feeds the serial input `x` of the sequence-detector Moore machine. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock. Consecutive words stream with no idle gap between them. When no word is pending, `x` rests at a fixed idle level so the downstream detector sees a clean, defined stream.

## Interface
- `WIDTH`, default 8: word length in bits; must be ≥ 2.
- `IDLE_BIT`, default 1'b0: level driven on `x` when no word is being shifted.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `data` in WIDTH: parallel word; sampled only on an accepting edge.
- `valid` in 1: producer has a word on `data`.
- `ready` out 1: block can accept a word this cycle.
- `x` out 1: serial bit to the detector; registered.
- `busy` out 1: a word is being shifted; registered.
- `last` out 1: the bit currently on `x` is bit 0 of the word; registered.

## Operation
- Internal state:
  - WIDTH-bit shift register `sr`.
  - Bit counter `cnt`, $clog2(WIDTH) bits wide.
  - Two-state FSM: IDLE and SHIFT.
- Accept condition is `valid && ready`, evaluated at the rising edge.
- `ready` is combinational: `reset && (state==IDLE || last)`.
  - `ready` is 0 while `reset` is low.
- IDLE:
  - `x=IDLE_BIT`, `busy=0`, `last=0`.
  - On accept: `sr<=data`, `cnt<=WIDTH-1`, `x<=data[WIDTH-1]`, go to SHIFT.
  - Without accept: remain in IDLE.
- SHIFT, with `cnt>0`:
  - Shift `sr` left by one.
  - `x<=sr[WIDTH-2]`, which is the next-lower bit.
  - `cnt<=cnt-1`.
  - `last<=(cnt==1)`.
- SHIFT, with `cnt==0` (the `last` cycle):
  - On accept: reload exactly as on an accept from IDLE. The first bit of the new word appears on the very next cycle, with no gap, and the FSM stays in SHIFT.
  - Without accept: `x<=IDLE_BIT`, `busy<=0`, `last<=0`, go to IDLE.
- Backpressure:
  - While `ready=0`, `valid` and `data` are ignored.
  - The producer must hold `valid` high until it is accepted.
- Reset:
  - Any edge with `reset=0` forces IDLE, `x=IDLE_BIT`, `busy=0`, `last=0`, `sr=0`, `cnt=0`.
  - This applies mid-word as well: the partial word is discarded and no further bits of it appear.
  - Reset takes priority over an accept on the same edge.
- The `default` FSM encoding recovers to IDLE.

## Timing
- Reset values, at the first edge with `reset=0`: `x=IDLE_BIT`, `busy=0`, `last=0`. `ready=0` while `reset` is low.
- Latency: word accepted at edge k gives:
  - `x=data[WIDTH-1]` during cycle k+1.
  - `x=data[WIDTH-1-i]` during cycle k+1+i.
  - `data[0]` during cycle k+WIDTH, with `last=1` and `ready=1`.
- `busy` is high from cycle k+1 through k+WIDTH inclusive.
- A back-to-back accept at edge k+WIDTH puts the next word's MSB in cycle k+WIDTH+1.
- Throughput: one bit per clock, sustained.
- Without a back-to-back accept, `x` returns to `IDLE_BIT` in cycle k+WIDTH+1.
- Earliest re-accept after reset release: the first edge with `reset=1` and `valid=1`.

## Test plan
- **Single word:** reset low for 1 edge, then `valid=1`, `data=8'hA5` for 1 edge.
  - Required: `x` = 1,0,1,0,0,1,0,1 over the next 8 cycles.
  - Required: `last` high only on the 8th bit, then `x=0` and `busy=0`.
- **Back-to-back:** `8'hAA` then `8'h0F`, with `valid` held high.
  - Required: 16 contiguous bits 1010101000001111.
  - Required: `ready` pulses high only on each `last` cycle.
  - Required: `busy` stays high for all 16 cycles.
  - When chained into the detector, it flags each completed 1010.
- **Backpressure:** `valid` asserted with `data=8'hFF` in the 3rd bit-cycle of a word.
  - Required: no accept until the `last` cycle.
  - Required: the in-flight word is unaltered.
  - Required: `8'hFF` follows with no gap.
- **Reset mid-word:** `reset=0` during the 4th bit of `8'hC3`.
  - Required: next cycle `x=IDLE_BIT`, `busy=0`, `last=0`.
  - Required: the remaining bits are never emitted.
- **Reset and accept on the same edge:** `reset=0` with `valid=1`.
  - Required: the word is not accepted and the block stays IDLE.
- **Idle level:** with `IDLE_BIT=1` and `WIDTH=4`, send `4'b0110`.
  - Required: `x` = 1 (idle), 0, 1, 1, 0, then 1 again.
  - Required: `last` on the 4th bit.
